// File: rtl/instr_buffer.sv
// instr_buffer: decoupling FIFO between fetch/decode and dispatch.
// Takes up to four decoded instructions per cycle in program order and
// presents the oldest four to dispatch. num_free tells fetch how many it
// may send next cycle. A flush (taken jump) empties the buffer.
module instr_buffer #(
   parameter int DEPTH   = 16,
   parameter int ENTRY_W = 26
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic [2:0]               in_count,
   input  logic [4*ENTRY_W-1:0]     in_entry,
   input  logic [2:0]               deq_count,
   output logic [3:0]               out_valid,
   output logic [4*ENTRY_W-1:0]     out_entry,
   output logic [2:0]               num_free,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     overflow_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]      head;
   logic [PW-1:0]      tail;
   logic [CW-1:0]      count;
   logic [ENTRY_W-1:0] mem [DEPTH];

   logic               accept;
   logic [CW-1:0]      eff_deq;
   logic [CW-1:0]      count_next;
   logic [CW-1:0]      free_next;
   logic [2:0]         num_free_next;
   logic [PW-1:0]      wr_idx [4];
   logic [PW-1:0]      rd_idx [4];

   // Admission uses the registered (pre-dequeue) free count, so a whole group
   // is either taken or refused; dequeue is clamped to what is actually held.
   always_comb begin
      accept        = (in_count <= num_free);
      eff_deq       = (CW'(deq_count) < count) ? CW'(deq_count) : count;
      count_next    = count - eff_deq + (accept ? CW'(in_count) : '0);
      free_next     = CW'(DEPTH) - count_next;
      num_free_next = (free_next >= CW'(4)) ? 3'd4 : free_next[2:0];
      for (int i = 0; i < 4; i++) begin
         wr_idx[i] = tail + PW'(i);
         rd_idx[i] = head + PW'(i);
      end
   end

   // Pointers, count and the registered status flags; flush beats enqueue/dequeue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         num_free     <= 3'd4;
         overflow_err <= 1'b0;
      end else if (flush) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         num_free     <= 3'd4;
         overflow_err <= 1'b0;
      end else begin
         head         <= head + PW'(eff_deq);
         if (accept) begin
            tail      <= tail + PW'(in_count);
         end
         count        <= count_next;
         num_free     <= num_free_next;
         overflow_err <= ~accept;
      end
   end

   // Payload storage is deliberately not reset; only valid slots are ever shown.
   always_ff @(posedge clk) begin
      if (!flush && accept) begin
         for (int i = 0; i < 4; i++) begin
            if (3'(i) < in_count) begin
               mem[wr_idx[i]] <= in_entry[i*ENTRY_W +: ENTRY_W];
            end
         end
      end
   end

   // Oldest four entries from the head, wrapping; invalid lanes read as zero.
   always_comb begin
      out_valid = '0;
      out_entry = '0;
      for (int i = 0; i < 4; i++) begin
         out_valid[i] = (CW'(i) < count);
         if (out_valid[i]) begin
            out_entry[i*ENTRY_W +: ENTRY_W] = mem[rd_idx[i]];
         end
      end
   end

   assign occupancy = count;

endmodule

// File: tb/tb_instr_buffer.sv
// tb_instr_buffer: table-driven, directed and randomized checks of
// instr_buffer against a queue-based reference model.
module tb_instr_buffer;

   localparam int DEPTH   = 16;
   localparam int ENTRY_W = 26;

   logic                   clk;
   logic                   rst_n;
   logic                   flush;
   logic [2:0]             in_count;
   logic [4*ENTRY_W-1:0]   in_entry;
   logic [2:0]             deq_count;
   logic [3:0]             out_valid;
   logic [4*ENTRY_W-1:0]   out_entry;
   logic [2:0]             num_free;
   logic [4:0]             occupancy;
   logic                   overflow_err;

   int checks = 0;
   int errors = 0;

   logic [ENTRY_W-1:0] mdl_q [$];
   logic               mdl_ovf;
   logic [ENTRY_W-1:0] lanes [4];

   typedef struct {
      logic [2:0] in_cnt;
      logic [2:0] deq_cnt;
      logic       do_flush;
      int         exp_occ;
      logic [2:0] exp_free;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs [14];

   instr_buffer #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_count     (in_count),
      .in_entry     (in_entry),
      .deq_count    (deq_count),
      .out_valid    (out_valid),
      .out_entry    (out_entry),
      .num_free     (num_free),
      .occupancy    (occupancy),
      .overflow_err (overflow_err)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int model_free();
      int room;
      room = DEPTH - mdl_q.size();
      return (room > 4) ? 4 : room;
   endfunction

   // Compare every DUT output against the reference model.
   task automatic checkOutput(input string tag);
      logic [3:0]           exp_valid;
      logic [4*ENTRY_W-1:0] exp_entry;
      exp_valid = '0;
      exp_entry = '0;
      for (int i = 0; i < 4; i++) begin
         if (i < mdl_q.size()) begin
            exp_valid[i] = 1'b1;
            exp_entry[i*ENTRY_W +: ENTRY_W] = mdl_q[i];
         end
      end
      check_val({tag, ".occupancy"}, 128'(occupancy), 128'(mdl_q.size()));
      check_val({tag, ".num_free"}, 128'(num_free), 128'(model_free()));
      check_val({tag, ".overflow_err"}, 128'(overflow_err), 128'(mdl_ovf));
      check_val({tag, ".out_valid"}, 128'(out_valid), 128'(exp_valid));
      check_val({tag, ".out_entry"}, 128'(out_entry), 128'(exp_entry));
   endtask

   // Drive one cycle of inputs with fresh random payloads, advance the model,
   // clock once and compare.
   task automatic applyStimulus(input logic [2:0] ic, input logic [2:0] dc, input logic fl, input string tag);
      int free_now;
      int eff;
      for (int i = 0; i < 4; i++) begin
         lanes[i] = ENTRY_W'($urandom());
         in_entry[i*ENTRY_W +: ENTRY_W] = lanes[i];
      end
      in_count  = ic;
      deq_count = dc;
      flush     = fl;
      if (fl) begin
         mdl_q.delete();
         mdl_ovf = 1'b0;
      end else begin
         free_now = model_free();
         eff = (int'(dc) < mdl_q.size()) ? int'(dc) : mdl_q.size();
         for (int i = 0; i < eff; i++) void'(mdl_q.pop_front());
         if (int'(ic) <= free_now) begin
            for (int i = 0; i < int'(ic); i++) mdl_q.push_back(lanes[i]);
            mdl_ovf = 1'b0;
         end else begin
            mdl_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_count  = '0;
      deq_count = '0;
      in_entry  = '0;
      mdl_q.delete();
      mdl_ovf   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{3'd4, 3'd0, 1'b0,  4, 3'd4, 1'b0};
      vecs[1]  = '{3'd4, 3'd0, 1'b0,  8, 3'd4, 1'b0};
      vecs[2]  = '{3'd4, 3'd0, 1'b0, 12, 3'd4, 1'b0};
      vecs[3]  = '{3'd4, 3'd0, 1'b0, 16, 3'd0, 1'b0};
      vecs[4]  = '{3'd1, 3'd0, 1'b0, 16, 3'd0, 1'b1};
      vecs[5]  = '{3'd0, 3'd0, 1'b0, 16, 3'd0, 1'b0};
      vecs[6]  = '{3'd0, 3'd2, 1'b0, 14, 3'd2, 1'b0};
      vecs[7]  = '{3'd3, 3'd0, 1'b0, 14, 3'd2, 1'b1};
      vecs[8]  = '{3'd2, 3'd3, 1'b0, 13, 3'd3, 1'b0};
      vecs[9]  = '{3'd0, 3'd4, 1'b0,  9, 3'd4, 1'b0};
      vecs[10] = '{3'd0, 3'd4, 1'b0,  5, 3'd4, 1'b0};
      vecs[11] = '{3'd0, 3'd3, 1'b0,  2, 3'd4, 1'b0};
      vecs[12] = '{3'd0, 3'd4, 1'b0,  0, 3'd4, 1'b0};
      vecs[13] = '{3'd0, 3'd4, 1'b0,  0, 3'd4, 1'b0};

      do_reset();

      // Table: fill, overflow, admission-vs-dequeue, drain past empty.
      for (int v = 0; v < 14; v++) begin
         applyStimulus(vecs[v].in_cnt, vecs[v].deq_cnt, vecs[v].do_flush, $sformatf("vec%0d", v));
         check_val($sformatf("vec%0d.tbl_occ", v), 128'(occupancy), 128'(vecs[v].exp_occ));
         check_val($sformatf("vec%0d.tbl_free", v), 128'(num_free), 128'(vecs[v].exp_free));
         check_val($sformatf("vec%0d.tbl_ovf", v), 128'(overflow_err), 128'(vecs[v].exp_ovf));
      end

      // Wrap: tail at 14, head at 13, then a group straddling slot 15 -> 0.
      do_reset();
      applyStimulus(3'd4, 3'd0, 1'b0, "wrap_fill0");
      applyStimulus(3'd4, 3'd0, 1'b0, "wrap_fill1");
      applyStimulus(3'd4, 3'd0, 1'b0, "wrap_fill2");
      applyStimulus(3'd2, 3'd0, 1'b0, "wrap_fill3");
      applyStimulus(3'd0, 3'd4, 1'b0, "wrap_drain0");
      applyStimulus(3'd0, 3'd4, 1'b0, "wrap_drain1");
      applyStimulus(3'd0, 3'd4, 1'b0, "wrap_drain2");
      applyStimulus(3'd0, 3'd1, 1'b0, "wrap_drain3");
      applyStimulus(3'd4, 3'd0, 1'b0, "wrap_straddle");
      check_val("wrap.occ_const", 128'(occupancy), 128'(5));
      check_val("wrap.valid_const", 128'(out_valid), 128'(4'b1111));

      // Flush with 9 held and a simultaneous full enqueue.
      applyStimulus(3'd4, 3'd0, 1'b0, "pre_flush");
      check_val("pre_flush.occ_const", 128'(occupancy), 128'(9));
      applyStimulus(3'd4, 3'd2, 1'b1, "flush");
      check_val("flush.occ_const", 128'(occupancy), 128'(0));
      check_val("flush.free_const", 128'(num_free), 128'(4));

      // Async reset mid-stream must clear outputs before the next edge.
      applyStimulus(3'd4, 3'd0, 1'b0, "pre_async");
      applyStimulus(3'd3, 3'd0, 1'b0, "pre_async2");
      #2;
      rst_n = 1'b0;
      #1;
      mdl_q.delete();
      mdl_ovf = 1'b0;
      checkOutput("async_reset");
      check_val("async_reset.valid_const", 128'(out_valid), 128'(0));
      @(posedge clk);
      #1;
      // Release reset into a cycle that also flushes and enqueues.
      rst_n = 1'b1;
      applyStimulus(3'd4, 3'd0, 1'b1, "flush_on_release");

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         applyStimulus(3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
                       ($urandom_range(0, 39) == 0), $sformatf("rand%0d", n));
      end

      in_count  = '0;
      deq_count = '0;
      flush     = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
